// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue arbiter sharing one FPU between two requesters; one op in flight.
// Define FPU_ARB_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYC cycles.
module fpu_issue_arbiter #(
   parameter int unsigned DATA_W      = 128,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              fpu_valid,
   output logic [DATA_W-1:0] fpu_data,
   input  logic              fpu_complete,
   input  logic [31:0]       fpu_result,
   input  logic [4:0]        fpu_flags,
   output logic              rsp_valid,
   output logic              rsp_id,
   output logic [31:0]       rsp_result,
   output logic [4:0]        rsp_flags,
   input  logic              rsp_ready,
   output logic              busy,
   output logic              timeout_err
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic              rr_q, rr_d;
   logic              id_q, id_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [31:0]       result_q, result_d;
   logic [4:0]        flags_q, flags_d;
   logic              gnt_valid;
   logic              gnt_id;
   logic              timeout;

   // Ties go to the requester that was not served last; nothing is granted while in reset.
   always_comb begin
      gnt_valid = (req0_valid | req1_valid) & ~rst;
      if (req0_valid && req1_valid) begin
         gnt_id = ~rr_q;
      end else begin
         gnt_id = req1_valid;
      end
   end

`ifdef FPU_ARB_TIMEOUT_EN
   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);

   logic [15:0] cnt_q, cnt_d;

   // Held at zero outside WAIT, so it is clear on every entry to WAIT.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q != StWait) begin
         cnt_d = '0;
      end else if (!fpu_complete) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout = (state_q == StWait) && !fpu_complete && (cnt_q == TimeoutLast);
`else
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
   assign timeout            = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      id_d       = id_q;
      data_d     = data_q;
      result_d   = result_q;
      flags_d    = flags_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (gnt_valid) begin
               req0_ready = ~gnt_id;
               req1_ready = gnt_id;
               data_d     = gnt_id ? req1_data : req0_data;
               id_d       = gnt_id;
               state_d    = StIssue;
            end
         end
         StIssue: begin
            if (fpu_complete) begin
               result_d = fpu_result;
               flags_d  = fpu_flags;
               state_d  = StResp;
            end else begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (fpu_complete) begin
               result_d = fpu_result;
               flags_d  = fpu_flags;
               state_d  = StResp;
            end else if (timeout) begin
               result_d = 32'h7FC0_0000;
               flags_d  = 5'b10000;
               state_d  = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rr_d    = id_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         rr_q     <= 1'b0;
         id_q     <= 1'b0;
         data_q   <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         id_q     <= id_d;
         data_q   <= data_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign fpu_valid   = (state_q == StIssue);
   assign fpu_data    = data_q;
   assign rsp_valid   = (state_q == StResp);
   assign rsp_id      = id_q;
   assign rsp_result  = result_q;
   assign rsp_flags   = flags_q;
   assign busy        = (state_q != StIdle);
   assign timeout_err = timeout;

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Scoreboard bench for fpu_issue_arbiter: directed ops push expectations, a monitor pops them.
// Timeout scenarios run only when FPU_ARB_TIMEOUT_EN is defined.
module tb_fpu_issue_arbiter;

   localparam logic [31:0] NanRes = 32'h7FC0_0000;
`ifdef FPU_ARB_TIMEOUT_EN
   localparam int LongLat   = 7;
   localparam int ExpPulses = 1;
`else
   localparam int LongLat   = 20;
   localparam int ExpPulses = 0;
`endif

   localparam logic [127:0] P0 = {32'h0020_F053, 32'h3F80_0000, 32'h4000_0000, 32'h0};
   localparam logic [127:0] P1 = {32'h1010_0053, 32'h3F80_0000, 32'h0, 32'h0};
   localparam logic [127:0] PA = {32'h0830_F0D3, 32'h4040_0000, 32'h4080_0000, 32'h0};
   localparam logic [127:0] PB = {32'h1830_F153, 32'hC000_0000, 32'h3F00_0000, 32'h1};
   localparam logic [127:0] PC = {32'h5800_F1D3, 32'h4110_0000, 32'h0, 32'h0};
   localparam logic [127:0] PD = {32'h2000_0253, 32'h0000_0001, 32'h8000_0001, 32'h2};
   localparam logic [127:0] PE = {32'h1850_72D3, 32'h3F80_0000, 32'h0, 32'h3};
   localparam logic [127:0] PF = {32'h0060_8353, 32'h4120_0000, 32'h4120_0000, 32'h4};
   localparam logic [127:0] PG = {32'h5800_03D3, 32'hBF80_0000, 32'h0, 32'h5};
   localparam logic [127:0] PH = {32'h0000_0453, 32'h4000_0000, 32'h4000_0000, 32'h6};

   typedef struct packed {
      logic        id;
      logic [31:0] res;
      logic [4:0]  flg;
   } rsp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req1_valid, req0_ready, req1_ready;
   logic [127:0] req0_data, req1_data, fpu_data;
   logic         fpu_valid, fpu_complete;
   logic [31:0]  fpu_result, rsp_result;
   logic [4:0]   fpu_flags, rsp_flags;
   logic         rsp_valid, rsp_id, rsp_ready, busy, timeout_err;

   int           cyc = 0;
   int           n_checks = 0;
   int           n_fail = 0;
   int           to_pulses = 0;
   logic [127:0] exp_issue[$];
   rsp_t         exp_rsp[$];
   logic [127:0] mon_data;
   rsp_t         mon_rsp;

   fpu_issue_arbiter #(
      .DATA_W      (128),
      .TIMEOUT_CYC (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req0_valid   (req0_valid),
      .req0_data    (req0_data),
      .req0_ready   (req0_ready),
      .req1_valid   (req1_valid),
      .req1_data    (req1_data),
      .req1_ready   (req1_ready),
      .fpu_valid    (fpu_valid),
      .fpu_data     (fpu_data),
      .fpu_complete (fpu_complete),
      .fpu_result   (fpu_result),
      .fpu_flags    (fpu_flags),
      .rsp_valid    (rsp_valid),
      .rsp_id       (rsp_id),
      .rsp_result   (rsp_result),
      .rsp_flags    (rsp_flags),
      .rsp_ready    (rsp_ready),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: samples on the falling edge, pops expectations on issue and response handshakes.
   always @(negedge clk) begin
      if (!rst) begin
         check("single_grant", 128'(req0_ready & req1_ready), 128'(0));
         if (fpu_valid) begin
            if (exp_issue.size() == 0) begin
               check("unexpected_issue", 128'(fpu_valid), 128'(0));
            end else begin
               mon_data = exp_issue.pop_front();
               check("fpu_data", fpu_data, mon_data);
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) begin
               check("unexpected_rsp", 128'(rsp_valid), 128'(0));
            end else begin
               mon_rsp = exp_rsp.pop_front();
               check("rsp_id", 128'(rsp_id), 128'(mon_rsp.id));
               check("rsp_result", 128'(rsp_result), 128'(mon_rsp.res));
               check("rsp_flags", 128'(rsp_flags), 128'(mon_rsp.flg));
            end
         end
         if (timeout_err) to_pulses++;
      end
   end

   // Raise a request, wait for its ready, drop valid after the accepting edge.
   task automatic request(input int who, input logic [127:0] d, output int t_acc);
      int n;
      if (who == 0) begin
         req0_valid = 1'b1;
         req0_data  = d;
      end else begin
         req1_valid = 1'b1;
         req1_data  = d;
      end
      n = 0;
      @(negedge clk);
      while (!((who == 0) ? req0_ready : req1_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_ready", 128'((who == 0) ? req0_ready : req1_ready), 128'(1));
      t_acc = cyc;
      @(posedge clk);
      #1;
      if (who == 0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
   endtask

   // FPU model for one op: completes lat cycles after the issue cycle (0 = same cycle).
   task automatic serve(input logic id, input logic [127:0] data, input int lat,
                        input logic [31:0] res, input logic [4:0] flg, input int hold,
                        input bit spur, input bit drop, output int t_issue, output int t_rsp);
      int n;
      exp_issue.push_back(data);
      exp_rsp.push_back({id, res, flg});
      t_issue = -1;
      t_rsp   = -1;
      n = 0;
      @(negedge clk);
      while (!fpu_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("issue_seen", 128'(fpu_valid), 128'(1));
      if (!fpu_valid) return;
      t_issue    = cyc;
      fpu_result = res;
      fpu_flags  = flg;
      if (lat == 0) begin
         fpu_complete = 1'b1;
         @(posedge clk);
         #1;
         fpu_complete = 1'b0;
         if (drop) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
      end else begin
         @(posedge clk);
         #1;
         if (drop) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
         repeat (lat - 1) begin
            @(posedge clk);
            #1;
         end
         fpu_complete = 1'b1;
         @(posedge clk);
         #1;
         fpu_complete = 1'b0;
      end
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rsp_seen", 128'(rsp_valid), 128'(1));
      t_rsp = cyc;
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 128'(rsp_valid), 128'(1));
         check("hold_id", 128'(rsp_id), 128'(id));
         check("hold_result", 128'(rsp_result), 128'(res));
         check("hold_flags", 128'(rsp_flags), 128'(flg));
         check("hold_no_ready", 128'(req0_ready | req1_ready), 128'(0));
         @(posedge clk);
         #1;
         fpu_complete = spur && (i == 0);
         if (spur && i == 0) begin
            fpu_result = 32'hDEAD_BEEF;
            fpu_flags  = 5'h1F;
         end
         @(negedge clk);
      end
      if (hold > 0) begin
         @(posedge clk);
         #1;
         fpu_complete = 1'b0;
         rsp_ready    = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_fpu_valid"}, 128'(fpu_valid), 128'(0));
      check({tag, "_fpu_data"}, fpu_data, 128'(0));
      check({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
      check({tag, "_rsp_id"}, 128'(rsp_id), 128'(0));
      check({tag, "_rsp_result"}, 128'(rsp_result), 128'(0));
      check({tag, "_rsp_flags"}, 128'(rsp_flags), 128'(0));
      check({tag, "_busy"}, 128'(busy), 128'(0));
      check({tag, "_timeout_err"}, 128'(timeout_err), 128'(0));
      check({tag, "_req0_ready"}, 128'(req0_ready), 128'(0));
   endtask

   initial begin
      int ta, ti, tr, n, nw;
      rst          = 1'b1;
      req0_valid   = 1'b1;
      req1_valid   = 1'b0;
      req0_data    = P0;
      req1_data    = '0;
      fpu_complete = 1'b0;
      fpu_result   = '0;
      fpu_flags    = '0;
      rsp_ready    = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk);
      #1;
      rst        = 1'b0;
      req0_valid = 1'b0;

      // Single req0 op, FPU completes one cycle after issue.
      request(0, P0, ta);
      serve(1'b0, P0, 1, 32'h4040_0000, 5'b0, 0, 1'b0, 1'b0, ti, tr);
      check("t1_issue_lat", 128'(ti), 128'(ta + 1));
      check("t1_rsp_lat", 128'(tr), 128'(ta + 3));
      @(negedge clk);
      check("t1_busy_idle", 128'(busy), 128'(0));

      // Spurious completion while idle.
      @(posedge clk);
      #1;
      fpu_complete = 1'b1;
      fpu_result   = 32'hDEAD_BEEF;
      fpu_flags    = 5'h1F;
      @(posedge clk);
      #1;
      fpu_complete = 1'b0;
      @(negedge clk);
      check("spur_idle_busy", 128'(busy), 128'(0));
      check("spur_idle_rsp_valid", 128'(rsp_valid), 128'(0));
      check("spur_idle_result", 128'(rsp_result), 128'(32'h4040_0000));
      check("spur_idle_flags", 128'(rsp_flags), 128'(0));
      @(posedge clk);
      #1;

      // Single-cycle op: minimum latency.
      request(0, P1, ta);
      serve(1'b0, P1, 0, 32'h3F80_0000, 5'b00001, 0, 1'b0, 1'b0, ti, tr);
      check("min_issue_lat", 128'(ti), 128'(ta + 1));
      check("min_rsp_lat", 128'(tr), 128'(ta + 2));

      // Both valid continuously: last served was 0, so order is 1,0,1,0.
      req0_valid = 1'b1;
      req0_data  = PA;
      req1_valid = 1'b1;
      req1_data  = PB;
      serve(1'b1, PB, 1, 32'h4140_0000, 5'b0, 0, 1'b0, 1'b0, ti, tr);
      serve(1'b0, PA, 0, 32'hBF00_0000, 5'b00001, 0, 1'b0, 1'b0, ti, tr);
      serve(1'b1, PB, 2, 32'h7F80_0000, 5'b00101, 0, 1'b0, 1'b0, ti, tr);
      serve(1'b0, PA, 3, 32'h0000_0000, 5'b00011, 0, 1'b0, 1'b1, ti, tr);

      // Long op, response held 5 cycles with a spurious completion in RESP; req1 waits.
      rsp_ready = 1'b0;
      request(0, PC, ta);
      req1_valid = 1'b1;
      req1_data  = PD;
      serve(1'b0, PC, LongLat, 32'h4040_0000, 5'b00001, 5, 1'b1, 1'b0, ti, tr);
      check("long_rsp_lat", 128'(tr), 128'(ti + LongLat + 1));
      serve(1'b1, PD, 1, 32'h8000_0000, 5'b00010, 0, 1'b0, 1'b1, ti, tr);

      // Reset while waiting; the stale completion afterwards must be ignored.
      exp_issue.push_back(PE);
      request(1, PE, ta);
      @(negedge clk);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst        = 1'b1;
      req0_valid = 1'b1;
      @(negedge clk);
      check_all_zero("wait_reset");
      @(posedge clk);
      #1;
      rst          = 1'b0;
      req0_valid   = 1'b0;
      fpu_complete = 1'b1;
      fpu_result   = 32'h1234_5678;
      fpu_flags    = 5'h1F;
      @(posedge clk);
      #1;
      fpu_complete = 1'b0;
      @(negedge clk);
      check("stale_busy", 128'(busy), 128'(0));
      check("stale_rsp_valid", 128'(rsp_valid), 128'(0));
      check("stale_result", 128'(rsp_result), 128'(0));
      check("stale_flags", 128'(rsp_flags), 128'(0));
      @(posedge clk);
      #1;
      request(1, PF, ta);
      serve(1'b1, PF, 2, 32'h42C8_0000, 5'b0, 0, 1'b0, 1'b0, ti, tr);
      check("post_reset_rsp_lat", 128'(tr), 128'(ta + 4));

`ifdef FPU_ARB_TIMEOUT_EN
      // FPU never completes: exactly 8 WAIT cycles then a NaN response.
      exp_issue.push_back(PG);
      exp_rsp.push_back({1'b0, NanRes, 5'b10000});
      request(0, PG, ta);
      n  = 0;
      nw = 0;
      @(negedge clk);
      while (!rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
         if (busy && !fpu_valid && !rsp_valid) nw++;
      end
      check("to_rsp_seen", 128'(rsp_valid), 128'(1));
      check("to_wait_cycles", 128'(nw), 128'(8));
      @(posedge clk);
      #1;
      // Completion on the 8th WAIT cycle wins over the timeout.
      request(1, PH, ta);
      serve(1'b1, PH, 8, 32'h4080_0000, 5'b0, 0, 1'b0, 1'b0, ti, tr);
      check("to_edge_rsp_lat", 128'(tr), 128'(ti + 9));
`endif

      repeat (4) @(negedge clk);
      check("issue_queue_drained", 128'(exp_issue.size()), 128'(0));
      check("rsp_queue_drained", 128'(exp_rsp.size()), 128'(0));
      check("timeout_pulses", 128'(to_pulses), 128'(ExpPulses));
      check("fpu_data_held", fpu_data, (ExpPulses != 0) ? PH : PF);
      check("final_busy", 128'(busy), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fpu_issue_arbiter.md
Name: fpu_issue_arbiter

Overview:
- Shares the single FPU execution datapath between two instruction requesters, e.g. requester 0 = fetched-program decode path, requester 1 = host/debug injection port.
- Grants round-robin, holds one operation outstanding, and waits for FPU completion, whether single-cycle or multi-cycle.
- Returns the result and exception flags tagged with the requester ID.
- Sits between the decode stage and the FPU top, replacing direct decode-to-FPU wiring.

Parameters:
- DATA_W, 128: issue payload width = {instruction[31:0], fs1[31:0], fs2[31:0], fs3[31:0]}
- TIMEOUT_CYC, 64: WAIT-state cycle limit (used only with FPU_ARB_TIMEOUT_EN); legal range 2..65535.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_data  in  DATA_W  requester 0 payload
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid  in  1  requester 1 has an operation
- req1_data  in  DATA_W  requester 1 payload
- req1_ready  out  1  requester 1 accepted this cycle
- fpu_valid  out  1  one-cycle issue strobe to FPU
- fpu_data  out  DATA_W  registered payload to FPU
- fpu_complete  in  1  FPU result valid pulse
- fpu_result  in  32  FPU single-precision result
- fpu_flags  in  5  FPU exception flags {NV,DZ,OF,UF,NX}
- rsp_valid  out  1  response available
- rsp_id  out  1  requester that owns the response
- rsp_result  out  32  captured result
- rsp_flags  out  5  captured flags
- rsp_ready  in  1  consumer accepts response
- busy  out  1  state != IDLE
- timeout_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset, asynchronous and immediate on rst=1:
  - state=IDLE, rr_ptr=0.
  - All outputs 0; fpu_data=0; result/flag registers 0.
  - Any in-flight operation is dropped; a later fpu_complete is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If exactly one reqN_valid, grant N.
  - If both are valid, grant the requester != rr_ptr. rr_ptr holds the last-served ID, so after reset requester 1 wins a tie.
  - reqN_ready is combinational: 1 only in IDLE for the granted N. Handshake completes on valid&ready.
  - On grant: latch payload into fpu_data, latch ID, go to ISSUE.
- ISSUE:
  - fpu_valid=1 for exactly this cycle.
  - If fpu_complete=1 in the same cycle (single-cycle ops): capture fpu_result/fpu_flags, go to RESP.
  - Else go to WAIT.
- WAIT:
  - fpu_valid=0.
  - On fpu_complete: capture result/flags, go to RESP.
- RESP:
  - rsp_valid=1. rsp_id, rsp_result and rsp_flags stay stable until rsp_valid&rsp_ready.
  - On that handshake: rr_ptr<=rsp_id, go to IDLE.
  - A new grant happens no earlier than the next cycle; there is no IDLE bypass.
- Minimum latency: accept at cycle 0, fpu_valid at cycle 1, rsp_valid at cycle 2. Back-to-back throughput is 1 operation per 3 cycles.
- fpu_complete while in IDLE or RESP: ignored, no state change, captured data not overwritten.
- reqN_valid may drop without a handshake; it is not sampled outside IDLE.
- fpu_data holds its value after issue until the next grant.
- busy = (state != IDLE).

Optional Feature:
- Macro: FPU_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYC with no fpu_complete: go to RESP with rsp_result=32'h7FC00000 (canonical NaN), rsp_flags=5'b10000, and timeout_err=1 for that one cycle.
  - fpu_complete on the same cycle as the limit takes priority, so no timeout occurs.
- Undefined: no counter; WAIT is unbounded; timeout_err is tied to 0.

Test Plan:
- Reset then req0 only, FPU completes 1 cycle after issue with result 32'h40400000, flags 0:
  - req0_ready at cycle 0, fpu_valid at cycle 1, rsp_valid/rsp_id=0/rsp_result=32'h40400000 at cycle 2 or later.
  - busy returns to 0 after rsp_ready.
- Both requesters valid continuously for 4 ops: grant order 1,0,1,0.
  - fpu_data matches each owner's payload; no double grant.
- Multi-cycle op with fpu_complete 20 cycles after issue and rsp_ready held low 5 cycles:
  - rsp fields stable for all 5 cycles; no new req_ready until the handshake.
- Spurious fpu_complete in IDLE and in RESP: no state change; rsp_result unchanged.
- Assert rst in WAIT, then release and issue a new req1:
  - All outputs 0 during reset.
  - The stale completion from the old op arriving in the post-reset IDLE state is ignored.
  - req1 is served normally.
- FPU_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, FPU never completes:
  - rsp_result=32'h7FC00000, rsp_flags=5'b10000, timeout_err pulses once, exactly 8 WAIT cycles.
  - Variant: complete exactly on the 8th WAIT cycle gives the real result and no timeout_err.
